// File: rtl/multicycle_alu_if.sv
// Request/result port bundle for multicycle_alu: a valid/ready operation
// request from the operand-select logic and a valid/ready result toward the
// result bus, plus the busy indication.
interface multicycle_alu_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           op;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   result;
    logic                 overflow;
    logic                 div_by_zero;
    logic                 busy;

    // Requester/consumer side of the block
    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, overflow, div_by_zero, busy
    );

    // The ALU itself
    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, overflow, div_by_zero, busy
    );
endinterface

// File: rtl/multicycle_alu.sv
// Handshaked unsigned ALU. ADD/SUB/logic/CMP and divide-by-zero finish in one
// cycle; MUL (shift-add) and DIV (restoring) iterate for exactly WIDTH cycles.
// Each result is held on the output port until the consumer takes it, and a
// new op may be accepted in the same cycle the old result is consumed.
module multicycle_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    multicycle_alu_if.slave  bus
);
    localparam int RW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_CMP = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   b_q;
    logic [RW-1:0]      acc;
    logic [CNT_W-1:0]   cnt;
    logic [RW-1:0]      result_q;
    logic               ovf_q;
    logic               dz_q;
    logic               out_valid_q;
    logic               busy_q;

    logic               accept;
    logic               is_iter;
    logic [RW+1:0]      single_res;
    logic [WIDTH:0]     mul_sum;
    logic [RW-1:0]      mul_next;
    logic [WIDTH:0]     div_shift;
    logic               div_ok;
    logic [WIDTH-1:0]   div_rem;
    logic [RW-1:0]      div_next;
    logic [RW-1:0]      step_next;

    // Single-cycle result as {div_by_zero, overflow, result}. DIV only reaches
    // here when b==0; MUL never does.
    function automatic logic [RW+1:0] single_cycle(input logic [2:0]       f_op,
                                                   input logic [WIDTH-1:0] f_a,
                                                   input logic [WIDTH-1:0] f_b);
        logic [WIDTH:0]  sum;
        logic [RW-1:0]   res;
        logic            ovf;
        logic            dz;
        sum = {1'b0, f_a} + {1'b0, f_b};
        res = '0;
        ovf = 1'b0;
        dz  = 1'b0;
        case (f_op)
            OP_ADD: begin
                res = {{(WIDTH-1){1'b0}}, sum};
                ovf = sum[WIDTH];
            end
            OP_SUB: begin
                res = {{WIDTH{1'b0}}, f_a - f_b};
                ovf = (f_a < f_b);
            end
            OP_DIV: begin
                res = {f_a, {WIDTH{1'b1}}};
                dz  = 1'b1;
            end
            OP_AND: res = {{WIDTH{1'b0}}, f_a & f_b};
            OP_OR:  res = {{WIDTH{1'b0}}, f_a | f_b};
            OP_XOR: res = {{WIDTH{1'b0}}, f_a ^ f_b};
            OP_CMP: begin
                if (f_a > f_b)      res = {{(RW-3){1'b0}}, 3'b001};
                else if (f_a < f_b) res = {{(RW-3){1'b0}}, 3'b010};
                else                res = {{(RW-3){1'b0}}, 3'b100};
            end
            default: res = '0;
        endcase
        return {dz, ovf, res};
    endfunction

    assign accept  = bus.in_valid && bus.in_ready;
    assign is_iter = (bus.op == OP_MUL) || ((bus.op == OP_DIV) && (bus.b != '0));

    assign bus.in_ready    = (state == IDLE) || ((state == DONE) && bus.out_ready);
    assign bus.out_valid   = out_valid_q;
    assign bus.busy        = busy_q;
    assign bus.result      = result_q;
    assign bus.overflow    = ovf_q;
    assign bus.div_by_zero = dz_q;

    // One iteration step. acc holds {hi, lo}: for MUL hi is the partial
    // product and lo the remaining multiplier bits; for DIV hi is the partial
    // remainder and lo the dividend shifting into the quotient.
    always_comb begin
        single_res = single_cycle(bus.op, bus.a, bus.b);
        mul_sum    = {1'b0, acc[RW-1:WIDTH]} + (acc[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        mul_next   = {mul_sum, acc[WIDTH-1:1]};
        div_shift  = acc[RW-1:WIDTH-1];
        div_ok     = (div_shift >= {1'b0, b_q});
        div_rem    = div_ok ? (div_shift[WIDTH-1:0] - b_q) : div_shift[WIDTH-1:0];
        div_next   = {div_rem, acc[WIDTH-2:0], div_ok};
        step_next  = (op_q == OP_MUL) ? mul_next : div_next;
    end

    // Control FSM with registered outputs; reset abandons any op in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            op_q        <= OP_ADD;
            b_q         <= '0;
            acc         <= '0;
            cnt         <= '0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            dz_q        <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (accept) begin
            op_q <= bus.op;
            b_q  <= bus.b;
            acc  <= {{WIDTH{1'b0}}, bus.a};
            if (is_iter) begin
                state       <= CALC;
                cnt         <= CNT_W'(WIDTH);
                busy_q      <= 1'b1;
                out_valid_q <= 1'b0;
            end else begin
                state                     <= DONE;
                {dz_q, ovf_q, result_q}   <= single_res;
                busy_q                    <= 1'b0;
                out_valid_q               <= 1'b1;
            end
        end else begin
            case (state)
                CALC: begin
                    acc <= step_next;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state       <= DONE;
                        result_q    <= step_next;
                        ovf_q       <= (op_q == OP_MUL) && (step_next[RW-1:WIDTH] != '0);
                        dz_q        <= 1'b0;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu (WIDTH=8). Expected results come from
// an arithmetic model and travel through a scoreboard queue from issue to
// output.
module tb_multicycle_alu;
    localparam int W = 8;

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, MUL = 3'd2, DIV = 3'd3,
                           AND = 3'd4, OR  = 3'd5, XOR = 3'd6, CMP = 3'd7;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multicycle_alu_if #(.WIDTH(W)) bus();
    multicycle_alu #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [17:0] exp_q[$];   // {div_by_zero, overflow, result}

    // Reference model using plain integer arithmetic
    function automatic logic [17:0] model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        int ia, ib, r;
        logic ov, dz;
        ia = x; ib = y; r = 0; ov = 1'b0; dz = 1'b0;
        case (o)
            ADD: begin r = ia + ib; ov = (r > 255); end
            SUB: begin r = (ia - ib + 256) % 256; ov = (ia < ib); end
            MUL: begin r = ia * ib; ov = (r > 255); end
            DIV: if (ib == 0) begin r = ia * 256 + 255; dz = 1'b1; end
                 else r = (ia % ib) * 256 + ia / ib;
            AND: r = ia & ib;
            OR:  r = ia | ib;
            XOR: r = ia ^ ib;
            default: r = (ia > ib) ? 1 : ((ia < ib) ? 2 : 4);
        endcase
        return {dz, ov, r[15:0]};
    endfunction

    // Present a request, hold it until in_ready, push its expectation
    task automatic send(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y, output bit ok);
        bus.in_valid = 1'b1; bus.op = o; bus.a = x; bus.b = y;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.in_ready) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        exp_q.push_back(model(o, x, y));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Wait (bounded) for out_valid; latency counts cycles after the accept edge
    task automatic collect(output bit got, output int lat, output int bn);
        got = 1'b0; lat = 1; bn = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid) begin got = 1'b1; break; end
            if (bus.busy) bn++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.op = ADD; bus.a = '0; bus.b = '0;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b required 1 0 0",
                     bus.in_ready, bus.out_valid, bus.busy);
        else pass_cnt++;
        total_cnt++;
        if (bus.result !== 16'h0 || bus.overflow !== 1'b0 || bus.div_by_zero !== 1'b0)
            $display("FAIL reset_data: result=%h ovf=%b dz=%b required 0000 0 0",
                     bus.result, bus.overflow, bus.div_by_zero);
        else pass_cnt++;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_cycle();
        logic [2:0] to [11] = '{ADD, SUB, CMP, DIV, AND, OR, XOR, CMP, CMP, ADD, SUB};
        logic [7:0] ta [11] = '{200, 5, 3, 9, 8'hCC, 8'hCC, 8'hCC, 1, 9, 255, 7};
        logic [7:0] tb [11] = '{100, 7, 3, 0, 8'hAA, 8'hAA, 8'hAA, 2, 2, 255, 5};
        bit ok, got; int lat, bn; logic [17:0] e;
        for (int i = 0; i < 11; i++) begin
            send(to[i], ta[i], tb[i], ok);
            collect(got, lat, bn);
            e = exp_q.pop_front();
            total_cnt++;
            if (!ok || !got || lat != 1)
                $display("FAIL single_latency[%0d]: accepted=%b valid=%b latency=%0d required 1", i, ok, got, lat);
            else pass_cnt++;
            total_cnt++;
            if ({bus.div_by_zero, bus.overflow, bus.result} !== e)
                $display("FAIL single_result[%0d]: dz/ovf/result=%b/%b/%h required %b/%b/%h",
                         i, bus.div_by_zero, bus.overflow, bus.result, e[17], e[16], e[15:0]);
            else pass_cnt++;
        end
        @(posedge clk); #1;
        total_cnt++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL single_release: out_valid=%b in_ready=%b required 0 1", bus.out_valid, bus.in_ready);
        else pass_cnt++;
    endtask

    task automatic test_iterative();
        logic [2:0] to [8] = '{MUL, MUL, DIV, MUL, DIV, MUL, DIV, DIV};
        logic [7:0] ta [8] = '{15, 16, 200, 255, 0, 0, 255, 3};
        logic [7:0] tb [8] = '{17, 16, 7, 255, 5, 0, 1, 200};
        bit ok, got; int lat, bn; logic [17:0] e;
        for (int i = 0; i < 8; i++) begin
            send(to[i], ta[i], tb[i], ok);
            collect(got, lat, bn);
            e = exp_q.pop_front();
            total_cnt++;
            if (!ok || !got || lat != 9 || bn != 8)
                $display("FAIL iter_timing[%0d]: accepted=%b valid=%b latency=%0d busy=%0d required 9 8",
                         i, ok, got, lat, bn);
            else pass_cnt++;
            total_cnt++;
            if ({bus.div_by_zero, bus.overflow, bus.result} !== e)
                $display("FAIL iter_result[%0d]: dz/ovf/result=%b/%b/%h required %b/%b/%h",
                         i, bus.div_by_zero, bus.overflow, bus.result, e[17], e[16], e[15:0]);
            else pass_cnt++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        bit ok, got, blocked_ok; int lat, bn; logic [17:0] e;
        send(MUL, 8'd3, 8'd5, ok);
        bus.in_valid = 1'b1; bus.op = ADD; bus.a = 8'd1; bus.b = 8'd1;
        exp_q.push_back(model(ADD, 8'd1, 8'd1));
        blocked_ok = 1'b1; got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid) begin got = 1'b1; break; end
            if (bus.in_ready !== 1'b0) blocked_ok = 1'b0;
            @(posedge clk); #1;
        end
        total_cnt++;
        if (!ok || !got || !blocked_ok)
            $display("FAIL calc_blocks_input: accepted=%b valid=%b in_ready_low=%b required 1 1 1", ok, got, blocked_ok);
        else pass_cnt++;
        e = exp_q.pop_front();
        total_cnt++;
        if (bus.result !== e[15:0] || bus.in_ready !== 1'b1)
            $display("FAIL b2b_first: result=%h in_ready=%b required %h 1", bus.result, bus.in_ready, e[15:0]);
        else pass_cnt++;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        e = exp_q.pop_front();
        total_cnt++;
        if (bus.out_valid !== 1'b1 || bus.result !== e[15:0])
            $display("FAIL b2b_second: out_valid=%b result=%h required 1 %h", bus.out_valid, bus.result, e[15:0]);
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        bit ok, got, stable; int lat, bn; logic [17:0] e; logic [15:0] r0;
        bus.out_ready = 1'b0;
        send(MUL, 8'd16, 8'd16, ok);
        collect(got, lat, bn);
        e = exp_q.pop_front();
        r0 = bus.result;
        total_cnt++;
        if (!ok || !got || r0 !== e[15:0] || bus.overflow !== e[16])
            $display("FAIL bp_result: result=%h ovf=%b required %h %b", r0, bus.overflow, e[15:0], e[16]);
        else pass_cnt++;
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b1 || bus.result !== r0 || bus.in_ready !== 1'b0) stable = 1'b0;
        end
        total_cnt++;
        if (!stable)
            $display("FAIL bp_hold: out_valid=%b result=%h in_ready=%b required 1 %h 0",
                     bus.out_valid, bus.result, bus.in_ready, r0);
        else pass_cnt++;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.op = XOR; bus.a = 8'hF0; bus.b = 8'hFF;
        exp_q.push_back(model(XOR, 8'hF0, 8'hFF));
        #1;
        total_cnt++;
        if (bus.in_ready !== 1'b1)
            $display("FAIL bp_release_ready: in_ready=%b required 1", bus.in_ready);
        else pass_cnt++;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        e = exp_q.pop_front();
        total_cnt++;
        if (bus.out_valid !== 1'b1 || bus.result !== e[15:0])
            $display("FAIL bp_new_op: out_valid=%b result=%h required 1 %h", bus.out_valid, bus.result, e[15:0]);
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_streaming();
        int seen; logic [17:0] e; logic [7:0] x, y;
        seen = 0;
        for (int i = 0; i <= 10; i++) begin
            if (i > 0) begin
                if (bus.out_valid && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    seen++;
                    total_cnt++;
                    if ({bus.overflow, bus.result} !== e[16:0])
                        $display("FAIL stream[%0d]: ovf/result=%b/%h required %b/%h",
                                 i - 1, bus.overflow, bus.result, e[16], e[15:0]);
                    else pass_cnt++;
                end
            end
            if (i < 10) begin
                x = 8'($urandom_range(0, 255)); y = 8'($urandom_range(0, 255));
                bus.in_valid = 1'b1; bus.op = ADD; bus.a = x; bus.b = y;
                exp_q.push_back(model(ADD, x, y));
            end else begin
                bus.in_valid = 1'b0;
            end
            if (i < 10) begin @(posedge clk); #1; end
        end
        total_cnt++;
        if (seen != 10)
            $display("FAIL stream_count: results=%0d required 10", seen);
        else pass_cnt++;
        exp_q.delete();
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midop();
        bit ok, got, spurious; int lat, bn; logic [17:0] e;
        send(ADD, 8'd200, 8'd100, ok);
        collect(got, lat, bn);
        void'(exp_q.pop_front());
        send(MUL, 8'd20, 8'd30, ok);
        repeat (3) begin @(posedge clk); #1; end
        total_cnt++;
        if (bus.busy !== 1'b1)
            $display("FAIL midop_busy: busy=%b required 1", bus.busy);
        else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (bus.result !== 16'h0 || bus.overflow !== 1'b0 || bus.div_by_zero !== 1'b0 ||
            bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL async_reset: result=%h ovf=%b dz=%b out_valid=%b busy=%b in_ready=%b required 0000 0 0 0 0 1",
                     bus.result, bus.overflow, bus.div_by_zero, bus.out_valid, bus.busy, bus.in_ready);
        else pass_cnt++;
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        spurious = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0) spurious = 1'b1;
        end
        total_cnt++;
        if (spurious)
            $display("FAIL aborted_op_output: out_valid seen=%b required 0", spurious);
        else pass_cnt++;
        send(ADD, 8'd1, 8'd2, ok);
        collect(got, lat, bn);
        e = exp_q.pop_front();
        total_cnt++;
        if (!ok || !got || lat != 1 || bus.result !== e[15:0])
            $display("FAIL post_reset_add: latency=%0d result=%h required 1 %h", lat, bus.result, e[15:0]);
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_iterative();
        test_back_to_back();
        test_backpressure();
        test_streaming();
        test_reset_midop();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
